instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Converts symbolic LEGv8 instruction requests (mnemonic, registers, immediate) into 32-bit instruction words.
- Writes the words sequentially into instruction memory, so the bench and boot path can load programs without precomputed hex.
- It is the encode-side counterpart of the decode control path and uses the same opcode constants.
- Has a valid/ready request side, a registered memory-write side with backpressure, an auto-incrementing word address, and immediate range checking.

Parameters:
- ADDR_W, 16, width of the byte address into instruction memory. Wraps modulo 2^ADDR_W.
- ERR_CNT_W, 8, width of the saturating illegal-request counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_mnem  in  5  mnemonic code (`MN_*).
- in_rd  in  5  Rd/Rt.
- in_rn  in  5  Rn.
- in_rm  in  5  Rm.
- in_imm  in  26  immediate, two's complement.
- in_cond  in  4  B.cond condition code.
- base_load  in  1  load the address counter from base_addr.
- base_addr  in  ADDR_W  new start address. Low 2 bits are ignored (forced 0).
- wr_valid  out  1  instruction-memory write request.
- wr_ready  in  1  memory accepts the write.
- wr_addr  out  ADDR_W  byte address, word-aligned.
- wr_data  out  32  encoded instruction.
- err_pulse  out  1  one-cycle pulse when an illegal request is dropped.
- err_count  out  ERR_CNT_W  saturating count of dropped requests.
- words_written  out  ADDR_W-2  count of completed writes since reset or base_load.

Behaviour:
- Reset: wr_valid=0, wr_addr=0, wr_data=0, err_pulse=0, err_count=0, words_written=0, in_ready=1. Reset mid-write drops the pending word; no partial state survives.
- Pipeline: one-entry output register.
  - in_ready = !wr_valid || wr_ready (combinational).
  - A request accepted at edge N shows wr_valid=1 with its data from cycle N+1.
  - Back-to-back throughput is 1/cycle while wr_ready=1.
  - While wr_valid && !wr_ready: wr_addr and wr_data are held stable and in_ready=0.
- Address: on each write handshake (wr_valid && wr_ready), the counter += 4 and words_written += 1. wr_addr of a newly loaded word = the current counter. Wraps 2^ADDR_W-4 -> 0 silently.
- base_load:
  - Takes effect next cycle: counter <= {base_addr[ADDR_W-1:2],2'b00}, words_written <= 0.
  - A word already pending in the output register keeps its old address.
  - If base_load coincides with a write handshake, base_load wins (no +4).
  - Requests accepted in the same cycle as base_load use the new base.
- Encoding by format, with instruction bits [31:0]:
  - R (ADD SUB AND ORR ADDS SUBS ANDS): opcode11 | Rm | shamt=000000 | Rn | Rd. in_imm is ignored.
  - I (ADDI SUBI ANDI ORRI EORI ADDIS SUBIS ANDIS): opcode10 | imm12 | Rn | Rd. Legal when 0 <= in_imm <= 4095.
  - D (LDUR LDURB LDURH LDURSW STUR STURB STURH STURW): opcode11 | imm9 | op=00 | Rn | Rt. Legal when -256 <= in_imm <= 255.
  - CB (CBZ CBNZ): opcode8 | imm19 | Rt. Legal when -2^18 <= in_imm < 2^18.
  - BCOND: opcode 01010100 | imm19 | {1'b0,in_cond}. Same range as CB.
  - B: opcode 000101 | imm26. Always legal.
  - CMP: encoded as SUBS with Rd forced to 31.
  - CMPI: encoded as SUBIS with Rd forced to 31.
- Illegal request (mnemonic codes 29-31, or immediate out of range):
  - The request is still accepted (handshake completes) but is not written.
  - err_pulse=1 the following cycle; err_count += 1, saturating at all-ones.
  - The address counter is not advanced. The output register is untouched, so a pending legal word is unaffected.
- Simultaneous events: an accept and a write drain in the same cycle are legal; the register reloads and the address advances for the drained word. Counter arithmetic is ordered drain-then-assign, so the new word gets old counter + 4.

Decomposition:
- constants.vh holds the opcode macros shared with the decode control.
- Add to constants.vh: the `MN_* mnemonic codes (ADD=0, SUB=1, AND=2, ORR=3, ADDS=4, SUBS=5, ANDS=6, ADDI=7, SUBI=8, ANDI=9, ORRI=10, EORI=11, ADDIS=12, SUBIS=13, ANDIS=14, LDUR=15, LDURB=16, LDURH=17, LDURSW=18, STUR=19, STURB=20, STURH=21, STURW=22, CBZ=23, CBNZ=24, B=25, BCOND=26, CMP=27, CMPI=28) and the format codes R/I/D/B/CB.
- One combinational sub-module, instr_format_pack: (mnem, rd, rn, rm, imm, cond) -> (word[31:0], legal). The top level holds the handshake, output register, counters and error logic.

Test Plan:
1. Reset, then ADD rd=1 rn=2 rm=3 with wr_ready=1 -> one cycle later wr_valid=1, wr_addr=0x0000, wr_data=0x8B030041. Next word goes to 0x0004.
2. Stream ADDI rd=9 rn=9 imm=1, LDUR rd=0 rn=1 imm=8, B imm=-1, CBZ rd=5 imm=2 back-to-back -> data 0x91000529, 0xF8408020, 0x17FFFFFF, 0xB4000045 at addresses 0, 4, 8, 0xC on consecutive cycles; words_written=4.
3. Hold wr_ready=0 for 3 cycles with a word pending -> in_ready=0, wr_addr/wr_data stable. Release -> one write, then the next request proceeds.
4. ADDI imm=4096, then LDUR imm=256, then mnem=30 -> three err_pulse cycles, err_count=3, no wr_valid, address still 0. Then ADDI imm=4095 writes at address 0.
5. base_load base_addr=0xFFFD, then two ADD requests -> addresses 0xFFFC then 0x0000 (wrap), words_written=2. A base_load coinciding with a drain wins.
6. Assert reset while wr_valid=1 and wr_ready=0 -> next cycle wr_valid=0, counters=0, in_ready=1. The dropped word is never written.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// instr_encoder_pkg
//   Shared constants for the LEGv8 instruction encoder: mnemonic codes,
//   instruction format codes and the opcode fields used by the decode control.
package instr_encoder_pkg;

    // Mnemonic codes presented on in_mnem
    localparam logic [4:0] MN_ADD    = 5'd0;
    localparam logic [4:0] MN_SUB    = 5'd1;
    localparam logic [4:0] MN_AND    = 5'd2;
    localparam logic [4:0] MN_ORR    = 5'd3;
    localparam logic [4:0] MN_ADDS   = 5'd4;
    localparam logic [4:0] MN_SUBS   = 5'd5;
    localparam logic [4:0] MN_ANDS   = 5'd6;
    localparam logic [4:0] MN_ADDI   = 5'd7;
    localparam logic [4:0] MN_SUBI   = 5'd8;
    localparam logic [4:0] MN_ANDI   = 5'd9;
    localparam logic [4:0] MN_ORRI   = 5'd10;
    localparam logic [4:0] MN_EORI   = 5'd11;
    localparam logic [4:0] MN_ADDIS  = 5'd12;
    localparam logic [4:0] MN_SUBIS  = 5'd13;
    localparam logic [4:0] MN_ANDIS  = 5'd14;
    localparam logic [4:0] MN_LDUR   = 5'd15;
    localparam logic [4:0] MN_LDURB  = 5'd16;
    localparam logic [4:0] MN_LDURH  = 5'd17;
    localparam logic [4:0] MN_LDURSW = 5'd18;
    localparam logic [4:0] MN_STUR   = 5'd19;
    localparam logic [4:0] MN_STURB  = 5'd20;
    localparam logic [4:0] MN_STURH  = 5'd21;
    localparam logic [4:0] MN_STURW  = 5'd22;
    localparam logic [4:0] MN_CBZ    = 5'd23;
    localparam logic [4:0] MN_CBNZ   = 5'd24;
    localparam logic [4:0] MN_B      = 5'd25;
    localparam logic [4:0] MN_BCOND  = 5'd26;
    localparam logic [4:0] MN_CMP    = 5'd27;
    localparam logic [4:0] MN_CMPI   = 5'd28;

    typedef enum logic [2:0] {FmtR, FmtI, FmtD, FmtB, FmtCb} fmt_e;

    // R-format opcodes (11 bits)
    localparam logic [10:0] OP_ADD    = 11'b10001011000;
    localparam logic [10:0] OP_SUB    = 11'b11001011000;
    localparam logic [10:0] OP_AND    = 11'b10001010000;
    localparam logic [10:0] OP_ORR    = 11'b10101010000;
    localparam logic [10:0] OP_ADDS   = 11'b10101011000;
    localparam logic [10:0] OP_SUBS   = 11'b11101011000;
    localparam logic [10:0] OP_ANDS   = 11'b11101010000;
    // I-format opcodes (10 bits)
    localparam logic [9:0]  OP_ADDI   = 10'b1001000100;
    localparam logic [9:0]  OP_SUBI   = 10'b1101000100;
    localparam logic [9:0]  OP_ANDI   = 10'b1001001000;
    localparam logic [9:0]  OP_ORRI   = 10'b1011001000;
    localparam logic [9:0]  OP_EORI   = 10'b1101001000;
    localparam logic [9:0]  OP_ADDIS  = 10'b1011000100;
    localparam logic [9:0]  OP_SUBIS  = 10'b1111000100;
    localparam logic [9:0]  OP_ANDIS  = 10'b1111001000;
    // D-format opcodes (11 bits)
    localparam logic [10:0] OP_LDUR   = 11'b11111000010;
    localparam logic [10:0] OP_LDURB  = 11'b00111000010;
    localparam logic [10:0] OP_LDURH  = 11'b01111000010;
    localparam logic [10:0] OP_LDURSW = 11'b10111000100;
    localparam logic [10:0] OP_STUR   = 11'b11111000000;
    localparam logic [10:0] OP_STURB  = 11'b00111000000;
    localparam logic [10:0] OP_STURH  = 11'b01111000000;
    localparam logic [10:0] OP_STURW  = 11'b10111000000;
    // CB / B opcodes
    localparam logic [7:0]  OP_CBZ    = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ   = 8'b10110101;
    localparam logic [7:0]  OP_BCOND  = 8'b01010100;
    localparam logic [5:0]  OP_B      = 6'b000101;

endpackage

// File: rtl/instr_format_pack.sv
// instr_format_pack
//   Combinational encoder: symbolic request -> 32-bit LEGv8 word plus legality.
//   Ports: i_mnem/i_rd/i_rn/i_rm/i_imm/i_cond request fields,
//          o_word encoded instruction, o_legal known mnemonic and immediate in range.
module instr_format_pack
    import instr_encoder_pkg::*;
(
    input  logic [4:0]  i_mnem,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rn,
    input  logic [4:0]  i_rm,
    input  logic [25:0] i_imm,
    input  logic [3:0]  i_cond,
    output logic [31:0] o_word,
    output logic        o_legal
);

    fmt_e        w_fmt;
    logic [10:0] w_op11;
    logic [9:0]  w_op10;
    logic [7:0]  w_op8;
    logic [4:0]  w_rd;
    logic        w_known;
    logic        w_in_range;

    always_comb begin
        w_fmt   = FmtR;
        w_op11  = '0;
        w_op10  = '0;
        w_op8   = '0;
        w_rd    = i_rd;
        w_known = 1'b1;
        unique case (i_mnem)
            MN_ADD:    w_op11 = OP_ADD;
            MN_SUB:    w_op11 = OP_SUB;
            MN_AND:    w_op11 = OP_AND;
            MN_ORR:    w_op11 = OP_ORR;
            MN_ADDS:   w_op11 = OP_ADDS;
            MN_SUBS:   w_op11 = OP_SUBS;
            MN_ANDS:   w_op11 = OP_ANDS;
            MN_CMP:    begin w_op11 = OP_SUBS; w_rd = 5'd31; end
            MN_ADDI:   begin w_fmt = FmtI; w_op10 = OP_ADDI;  end
            MN_SUBI:   begin w_fmt = FmtI; w_op10 = OP_SUBI;  end
            MN_ANDI:   begin w_fmt = FmtI; w_op10 = OP_ANDI;  end
            MN_ORRI:   begin w_fmt = FmtI; w_op10 = OP_ORRI;  end
            MN_EORI:   begin w_fmt = FmtI; w_op10 = OP_EORI;  end
            MN_ADDIS:  begin w_fmt = FmtI; w_op10 = OP_ADDIS; end
            MN_SUBIS:  begin w_fmt = FmtI; w_op10 = OP_SUBIS; end
            MN_ANDIS:  begin w_fmt = FmtI; w_op10 = OP_ANDIS; end
            MN_CMPI:   begin w_fmt = FmtI; w_op10 = OP_SUBIS; w_rd = 5'd31; end
            MN_LDUR:   begin w_fmt = FmtD; w_op11 = OP_LDUR;   end
            MN_LDURB:  begin w_fmt = FmtD; w_op11 = OP_LDURB;  end
            MN_LDURH:  begin w_fmt = FmtD; w_op11 = OP_LDURH;  end
            MN_LDURSW: begin w_fmt = FmtD; w_op11 = OP_LDURSW; end
            MN_STUR:   begin w_fmt = FmtD; w_op11 = OP_STUR;   end
            MN_STURB:  begin w_fmt = FmtD; w_op11 = OP_STURB;  end
            MN_STURH:  begin w_fmt = FmtD; w_op11 = OP_STURH;  end
            MN_STURW:  begin w_fmt = FmtD; w_op11 = OP_STURW;  end
            MN_CBZ:    begin w_fmt = FmtCb; w_op8 = OP_CBZ;  end
            MN_CBNZ:   begin w_fmt = FmtCb; w_op8 = OP_CBNZ; end
            // B.cond reuses the CB layout with the condition in the Rt slot
            MN_BCOND:  begin w_fmt = FmtCb; w_op8 = OP_BCOND; w_rd = {1'b0, i_cond}; end
            MN_B:      w_fmt = FmtB;
            default:   w_known = 1'b0;
        endcase
    end

    always_comb begin
        o_word     = '0;
        w_in_range = 1'b1;
        unique case (w_fmt)
            FmtR: o_word = {w_op11, i_rm, 6'b000000, i_rn, w_rd};
            FmtI: begin
                o_word     = {w_op10, i_imm[11:0], i_rn, w_rd};
                w_in_range = (i_imm[25:12] == '0);
            end
            FmtD: begin
                o_word     = {w_op11, i_imm[8:0], 2'b00, i_rn, w_rd};
                // Sign-extension check: -256..255
                w_in_range = (i_imm[25:8] == '0) || (i_imm[25:8] == '1);
            end
            FmtCb: begin
                o_word     = {w_op8, i_imm[18:0], w_rd};
                w_in_range = (i_imm[25:18] == '0) || (i_imm[25:18] == '1);
            end
            FmtB: o_word = {OP_B, i_imm};
            default: o_word = '0;
        endcase
    end

    assign o_legal = w_known && w_in_range;

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder
//   Encodes symbolic LEGv8 requests and writes them sequentially into
//   instruction memory through a one-entry output register.
//   Ports: clk/reset (sync, active-high); in_* valid/ready request side;
//          base_load/base_addr restart the address counter; wr_* memory write
//          side with backpressure; err_pulse/err_count report dropped requests;
//          words_written counts completed writes since reset or base_load.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4:0]           in_mnem,
    input  logic [4:0]           in_rd,
    input  logic [4:0]           in_rn,
    input  logic [4:0]           in_rm,
    input  logic [25:0]          in_imm,
    input  logic [3:0]           in_cond,
    input  logic                 base_load,
    input  logic [ADDR_W-1:0]    base_addr,
    output logic                 wr_valid,
    input  logic                 wr_ready,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [31:0]          wr_data,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [ADDR_W-3:0]    words_written
);

    logic                 r_wr_valid;
    logic [ADDR_W-1:0]    r_wr_addr;
    logic [31:0]          r_wr_data;
    logic [ADDR_W-1:0]    r_addr;
    logic [ADDR_W-3:0]    r_words;
    logic                 r_err_pulse;
    logic [ERR_CNT_W-1:0] r_err_count;

    logic [31:0]       w_word;
    logic              w_legal;
    logic              w_accept;
    logic              w_drain;
    logic              w_drop;
    logic [ADDR_W-1:0] w_base;
    logic [ADDR_W-1:0] w_addr_next;
    logic              w_unused_base;

    instr_format_pack u_pack (
        .i_mnem  (in_mnem),
        .i_rd    (in_rd),
        .i_rn    (in_rn),
        .i_rm    (in_rm),
        .i_imm   (in_imm),
        .i_cond  (in_cond),
        .o_word  (w_word),
        .o_legal (w_legal)
    );

    assign in_ready = !r_wr_valid || wr_ready;
    assign w_accept = in_valid && in_ready;
    assign w_drain  = r_wr_valid && wr_ready;
    assign w_drop   = w_accept && !w_legal;
    assign w_base   = {base_addr[ADDR_W-1:2], 2'b00};
    assign w_unused_base = ^base_addr[1:0];

    // Drain first, then assign: a word accepted alongside a drain gets the
    // advanced counter. base_load overrides both.
    assign w_addr_next = base_load ? w_base
                       : (w_drain ? r_addr + ADDR_W'(4) : r_addr);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_valid  <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_addr      <= '0;
            r_words     <= '0;
            r_err_pulse <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_addr <= w_addr_next;

            if (base_load) begin
                r_words <= '0;
            end else if (w_drain) begin
                r_words <= r_words + (ADDR_W-2)'(1);
            end

            if (w_accept && w_legal) begin
                r_wr_valid <= 1'b1;
                r_wr_addr  <= w_addr_next;
                r_wr_data  <= w_word;
            end else if (w_drain) begin
                r_wr_valid <= 1'b0;
            end

            r_err_pulse <= w_drop;
            if (w_drop && (r_err_count != '1)) begin
                r_err_count <= r_err_count + ERR_CNT_W'(1);
            end
        end
    end

    assign wr_valid      = r_wr_valid;
    assign wr_addr       = r_wr_addr;
    assign wr_data       = r_wr_data;
    assign err_pulse     = r_err_pulse;
    assign err_count     = r_err_count;
    assign words_written = r_words;

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder
//   Directed bench for instr_encoder with hand-computed instruction words.
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_mnem;
    logic [4:0]  in_rd;
    logic [4:0]  in_rn;
    logic [4:0]  in_rm;
    logic [25:0] in_imm;
    logic [3:0]  in_cond;
    logic        base_load;
    logic [15:0] base_addr;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_addr;
    logic [31:0] wr_data;
    logic        err_pulse;
    logic [7:0]  err_count;
    logic [13:0] words_written;

    int n_tests = 0;
    int n_fail  = 0;

    instr_encoder #(.ADDR_W(16), .ERR_CNT_W(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_mnem       (in_mnem),
        .in_rd         (in_rd),
        .in_rn         (in_rn),
        .in_rm         (in_rm),
        .in_imm        (in_imm),
        .in_cond       (in_cond),
        .base_load     (base_load),
        .base_addr     (base_addr),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .err_pulse     (err_pulse),
        .err_count     (err_count),
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request for exactly one clock edge.
    task automatic req(input logic [4:0] m, input logic [4:0] rd, input logic [4:0] rn,
                       input logic [4:0] rm, input logic [25:0] imm);
        in_valid = 1'b1;
        in_mnem  = m;
        in_rd    = rd;
        in_rn    = rn;
        in_rm    = rm;
        in_imm   = imm;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_mnem = '0; in_rd = '0; in_rn = '0; in_rm = '0;
        in_imm = '0; in_cond = '0; base_load = 1'b0; base_addr = '0; wr_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_wr_valid", 32'(wr_valid), 32'h0);
        chk("rst_wr_addr", 32'(wr_addr), 32'h0);
        chk("rst_wr_data", wr_data, 32'h0);
        chk("rst_err_pulse", 32'(err_pulse), 32'h0);
        chk("rst_err_count", 32'(err_count), 32'h0);
        chk("rst_words", 32'(words_written), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);

        // 1: single ADD, then next word at 4
        req(MN_ADD, 5'd1, 5'd2, 5'd3, 26'd0);
        chk("t1_valid", 32'(wr_valid), 32'h1);
        chk("t1_addr", 32'(wr_addr), 32'h0);
        chk("t1_data", wr_data, 32'h8B030041);
        tick();
        chk("t1_drained", 32'(wr_valid), 32'h0);
        chk("t1_words", 32'(words_written), 32'h1);
        req(MN_ADD, 5'd1, 5'd2, 5'd3, 26'd0);
        chk("t1_next_addr", 32'(wr_addr), 32'h4);
        tick();

        // 2: back-to-back stream
        do_reset();
        in_valid = 1'b1;
        in_mnem = MN_ADDI; in_rd = 5'd9; in_rn = 5'd9; in_imm = 26'd1;
        tick();
        chk("t2_addi_addr", 32'(wr_addr), 32'h0);
        chk("t2_addi_data", wr_data, 32'h91000529);
        in_mnem = MN_LDUR; in_rd = 5'd0; in_rn = 5'd1; in_imm = 26'd8;
        tick();
        chk("t2_ldur_addr", 32'(wr_addr), 32'h4);
        chk("t2_ldur_data", wr_data, 32'hF8408020);
        in_mnem = MN_B; in_imm = 26'h3FF_FFFF;
        tick();
        chk("t2_b_addr", 32'(wr_addr), 32'h8);
        chk("t2_b_data", wr_data, 32'h17FFFFFF);
        in_mnem = MN_CBZ; in_rd = 5'd5; in_imm = 26'd2;
        tick();
        chk("t2_cbz_valid", 32'(wr_valid), 32'h1);
        chk("t2_cbz_addr", 32'(wr_addr), 32'hC);
        chk("t2_cbz_data", wr_data, 32'hB4000045);
        in_valid = 1'b0;
        tick();
        chk("t2_words", 32'(words_written), 32'h4);
        chk("t2_idle", 32'(wr_valid), 32'h0);

        // 3: backpressure
        wr_ready = 1'b0;
        req(MN_ADD, 5'd1, 5'd2, 5'd3, 26'd0);
        in_valid = 1'b1; in_mnem = MN_SUB; in_rd = 5'd4; in_rn = 5'd5; in_rm = 5'd6;
        for (int i = 0; i < 3; i++) begin
            chk("t3_in_ready", 32'(in_ready), 32'h0);
            chk("t3_hold_addr", 32'(wr_addr), 32'h10);
            chk("t3_hold_data", wr_data, 32'h8B030041);
            tick();
        end
        wr_ready = 1'b1;
        #1;
        chk("t3_release_ready", 32'(in_ready), 32'h1);
        tick();
        in_valid = 1'b0;
        chk("t3_sub_addr", 32'(wr_addr), 32'h14);
        chk("t3_sub_data", wr_data, 32'hCB0600A4);
        tick();
        chk("t3_words", 32'(words_written), 32'h6);

        // 4: illegal requests
        do_reset();
        req(MN_ADDI, 5'd1, 5'd2, 5'd0, 26'd4096);
        chk("t4_pulse_a", 32'(err_pulse), 32'h1);
        req(MN_LDUR, 5'd1, 5'd2, 5'd0, 26'd256);
        chk("t4_pulse_b", 32'(err_pulse), 32'h1);
        req(5'd30, 5'd1, 5'd2, 5'd0, 26'd0);
        chk("t4_pulse_c", 32'(err_pulse), 32'h1);
        chk("t4_count", 32'(err_count), 32'h3);
        chk("t4_no_write", 32'(wr_valid), 32'h0);
        req(MN_ADDI, 5'd1, 5'd2, 5'd0, 26'd4095);
        chk("t4_pulse_clear", 32'(err_pulse), 32'h0);
        chk("t4_legal_addr", 32'(wr_addr), 32'h0);
        chk("t4_legal_data", wr_data, 32'h913FFC41);
        req(MN_LDUR, 5'd0, 5'd1, 5'd0, 26'h3FF_FF00);
        chk("t4_ldur_neg_addr", 32'(wr_addr), 32'h4);
        chk("t4_ldur_neg_data", wr_data, 32'hF8500020);
        req(MN_CMP, 5'd0, 5'd2, 5'd3, 26'd0);
        chk("t4_cmp_data", wr_data, 32'hEB03005F);
        tick();
        chk("t4_count_hold", 32'(err_count), 32'h3);

        // 5: base_load and wrap
        do_reset();
        base_load = 1'b1; base_addr = 16'hFFFD;
        tick();
        base_load = 1'b0;
        req(MN_ADD, 5'd1, 5'd2, 5'd3, 26'd0);
        chk("t5_addr_top", 32'(wr_addr), 32'hFFFC);
        req(MN_ADD, 5'd1, 5'd2, 5'd3, 26'd0);
        chk("t5_addr_wrap", 32'(wr_addr), 32'h0);
        tick();
        chk("t5_words", 32'(words_written), 32'h2);
        req(MN_ADD, 5'd1, 5'd2, 5'd3, 26'd0);
        chk("t5_pending_addr", 32'(wr_addr), 32'h4);
        base_load = 1'b1; base_addr = 16'h0100;
        tick();
        base_load = 1'b0;
        chk("t5_bl_words", 32'(words_written), 32'h0);
        req(MN_ADD, 5'd1, 5'd2, 5'd3, 26'd0);
        chk("t5_bl_wins", 32'(wr_addr), 32'h0100);
        tick();

        // 6: reset mid-write
        wr_ready = 1'b0;
        req(MN_ADD, 5'd1, 5'd2, 5'd3, 26'd0);
        chk("t6_pending", 32'(wr_valid), 32'h1);
        do_reset();
        chk("t6_valid", 32'(wr_valid), 32'h0);
        chk("t6_addr", 32'(wr_addr), 32'h0);
        chk("t6_words", 32'(words_written), 32'h0);
        chk("t6_in_ready", 32'(in_ready), 32'h1);
        wr_ready = 1'b1;
        tick();
        chk("t6_never_written", 32'(wr_valid), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
